mul_32_seq: RTL and testbench

// - Multi-cycle unsigned 32x32->64 shift-add multiplier; ALU-side stage consuming add_32 sum each cycle.
// - Operand latch/sequencer feeds add_32, which forms partial sums; this block accumulates and shifts.
// - Used by the ALU/multiply path where single-cycle multiply is not affordable; start/busy/done handshake.

---
 rtl/mul_32_seq_pkg.sv | 15 +
 rtl/mul_32_seq_add.sv | 11 +
 rtl/mul_32_seq.sv | 98 +++++++++
 tb/tb_mul_32_seq.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/mul_32_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
package mul_32_seq_pkg;

    // Sequencer states, fixed 2-bit encoding
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // One iteration per multiplier bit
    localparam int MUL_ITER = 32;
    localparam int CNT_W    = 5;

endpackage

// File: rtl/mul_32_seq_add.sv
// Plain 32-bit adder used to form partial sums; it has no carry-out,
// so the caller recovers the carry from an unsigned compare.
module add_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] c
);

    assign c = a + b;

endmodule

// File: rtl/mul_32_seq.sv
// Multi-cycle unsigned 32x32->64 shift-add multiplier with start/busy/done.
// 32 iterations follow the accepting edge, then one finalize edge latches the
// product, raises done and drops busy (done at accept edge + 33).
// WIDTH must stay 32: the partial-sum adder is fixed at 32 bits.
module mul_32_seq
    import mul_32_seq_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter bit DONE_LEVEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    state_t             state;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic [CNT_W-1:0]   count;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH-1:0]   sum;
    logic               carry;

    // Add the multiplicand only when the current multiplier LSB is set
    assign addend = lo[0] ? mcand : '0;

    add_32 u_add (
        .a (hi),
        .b (addend),
        .c (sum)
    );

    // A wrapped sum is smaller than either operand, so this is the lost carry
    assign carry = (sum < hi);

    // Sequencer, accumulator shift and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            mcand   <= '0;
            hi      <= '0;
            lo      <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand <= a;
                        hi    <= '0;
                        lo    <= b;
                        count <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // {hi,lo} <= {carry, sum, lo[31:1]}
                    hi    <= {carry, sum[WIDTH-1:1]};
                    lo    <= {sum[0], lo[WIDTH-1:1]};
                    count <= count + 1'b1;
                    if (count == CNT_W'(MUL_ITER - 1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    if (busy) begin
                        // First cycle in DONE: publish the result
                        product <= {hi, lo};
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        if (!DONE_LEVEL)
                            state <= S_IDLE;
                    end else if (start) begin
                        // Held-done mode: a new start goes straight to RUN
                        mcand <= a;
                        hi    <= '0;
                        lo    <= b;
                        count <= '0;
                        done  <= 1'b0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_32_seq.sv
// Scoreboard bench for mul_32_seq: pulse-done and held-done instances.
module tb_mul_32_seq;

    typedef struct {
        logic [63:0] prod;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start1;
    logic [31:0] a0, b0, a1, b1;
    logic        busy0, done0, busy1, done1;
    logic [63:0] product0, product1;

    int   edges = 0;
    int   n_vec = 0;
    int   n_err = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic prev_done1 = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) edges <= edges + 1;

    mul_32_seq #(.WIDTH(32), .DONE_LEVEL(1'b0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .product(product0)
    );

    mul_32_seq #(.WIDTH(32), .DONE_LEVEL(1'b1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .product(product1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop an expectation whenever a result is presented
    always @(negedge clk) begin
        exp_t e;
        if (done0 === 1'b1) begin
            if (q0.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL done0_unexpected: got done at edge %0d expected none", edges);
            end else begin
                e = q0.pop_front();
                chk("product0", product0, e.prod);
                chk("done0_edge", 64'(edges), 64'(e.at));
            end
        end
        if (done1 === 1'b1 && !prev_done1) begin
            if (q1.size() == 0) begin
                n_vec++; n_err++;
                $display("FAIL done1_unexpected: got done at edge %0d expected none", edges);
            end else begin
                e = q1.pop_front();
                chk("product1", product1, e.prod);
                chk("done1_edge", 64'(edges), 64'(e.at));
            end
        end
        prev_done1 <= (done1 === 1'b1);
    end

    task automatic wait_idle(input int which, input int n);
        int k = 0;
        while (((which == 0) ? busy0 : busy1) !== 1'b0 && k < n) begin
            @(negedge clk);
            k++;
        end
        if (k >= n) begin
            n_vec++; n_err++;
            $display("FAIL wait_idle%0d: got busy after %0d cycles expected idle", which, n);
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [63:0] exp, input logic [63:0] prev);
        @(negedge clk);
        start0 = 1'b1; a0 = x; b0 = y;
        q0.push_back('{exp, edges + 1 + 33});
        @(negedge clk);
        start0 = 1'b0; a0 = $urandom; b0 = $urandom;
        chk("busy0_after_accept", 64'(busy0), 64'd1);
        chk("product0_held_in_run", product0, prev);
        wait_idle(0, 40);
    endtask

    initial begin
        int base;
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy0", 64'(busy0), 64'd0);
        chk("rst_done0", 64'(done0), 64'd0);
        chk("rst_product0", product0, 64'h0);
        chk("rst_product1", product1, 64'h0);
        rst = 1'b0;

        run_op(32'd1, 32'd7, 64'h0000000000000007, 64'h0);
        run_op(32'hFFFFFFFF, 32'd1, 64'h00000000FFFFFFFF, 64'h7);
        run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 64'h00000000FFFFFFFF);
        run_op(32'd0, 32'h12345678, 64'h0, 64'hFFFFFFFE00000001);

        // start re-pulsed mid-run must be ignored
        @(negedge clk);
        start0 = 1'b1; a0 = 32'd1; b0 = 32'd7;
        q0.push_back('{64'h7, edges + 1 + 33});
        @(negedge clk);
        start0 = 1'b0;
        repeat (9) @(negedge clk);
        start0 = 1'b1; a0 = 32'd3; b0 = 32'd3;
        @(negedge clk);
        start0 = 1'b0;
        chk("busy0_ignore_start", 64'(busy0), 64'd1);
        wait_idle(0, 40);
        run_op(32'd3, 32'd3, 64'h9, 64'h7);

        // reset mid-run aborts with no done
        @(negedge clk);
        start0 = 1'b1; a0 = 32'd5; b0 = 32'd5;
        @(negedge clk);
        start0 = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy0", 64'(busy0), 64'd0);
        chk("abort_done0", 64'(done0), 64'd0);
        chk("abort_product0", product0, 64'h0);
        repeat (40) @(negedge clk);

        // reset wins over start on the same edge
        rst = 1'b1; start0 = 1'b1; a0 = 32'd2; b0 = 32'd2;
        @(negedge clk);
        rst = 1'b0; start0 = 1'b0;
        chk("rst_over_start_busy0", 64'(busy0), 64'd0);
        run_op(32'd2, 32'd3, 64'h6, 64'h0);

        // held-done instance: back-to-back with start held high
        @(negedge clk);
        start1 = 1'b1; a1 = 32'd1; b1 = 32'd7;
        base = edges + 1;
        q1.push_back('{64'h7, base + 33});
        q1.push_back('{64'h9, base + 34 + 33});
        @(negedge clk);
        a1 = 32'd3; b1 = 32'd3;
        while (edges < base + 34) @(negedge clk);
        chk("b2b_busy1", 64'(busy1), 64'd1);
        chk("b2b_done1_dropped", 64'(done1), 64'd0);
        start1 = 1'b0;
        wait_idle(1, 40);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_done1", 64'(done1), 64'd1);
            chk("hold_product1", product1, 64'h9);
        end
        start1 = 1'b1; a1 = 32'd2; b1 = 32'd5;
        q1.push_back('{64'd10, edges + 1 + 33});
        @(negedge clk);
        start1 = 1'b0;
        chk("restart_done1_low", 64'(done1), 64'd0);
        chk("restart_busy1", 64'(busy1), 64'd1);
        wait_idle(1, 40);

        repeat (3) @(negedge clk);
        chk("q0_drained", 64'(q0.size()), 64'd0);
        chk("q1_drained", 64'(q1.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
